// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller for the processor shift datapath.
// An N-bit shift runs as N single-bit steps. Left steps go through the external
// combinational shift-left unit (sl_in -> sl_out). Right steps use an internal
// 1-bit shifter with optional sign fill. Start/done handshake, one op in flight.
//
// Handshake: start is sampled only while idle. The op is accepted on the edge
// that samples start=1 in IDLE. busy is high while the op is in flight (SHIFT
// and DONE states). done is a one-cycle registered pulse, and data_out is valid
// in that same cycle. data_out then holds until the next done. start while busy
// is ignored.
//
// Optional feature macro: SHIFT_SEQ_CARRY_EN adds the carry_out port, which
// reports the last bit shifted out of the accumulator.
module shift_sequencer #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic [WIDTH-1:0]   sl_in,
    input  logic [WIDTH-1:0]   sl_out,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    output logic               carry_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   acc_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               dir_q;
    logic               arith_q;
    logic               done_q;
    logic [WIDTH-1:0]   data_out_q;

    // Control strobes decoded from the current state.
    logic load;
    logic step;
    logic finish;

    // Result of one right step. The fill bit comes from the sign when arith is set.
    logic [WIDTH-1:0] right_step;
    assign right_step = {(arith_q ? acc_q[WIDTH-1] : 1'b0), acc_q[WIDTH-1:1]};

    // State register: reset returns to IDLE and aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a zero-length shift skips SHIFT. cnt==1 marks the final step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath strobes decoded from the current state.
    always_comb begin
        busy   = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state_q)
            S_IDLE:  load = start;
            S_SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
            end
            S_DONE: begin
                busy   = 1'b1;
                finish = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: latch the operands on accept, take one step per SHIFT cycle,
    // and publish the result in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            arith_q    <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            done_q <= finish;
            if (load) begin
                acc_q   <= data_in;
                cnt_q   <= shamt;
                dir_q   <= dir;
                arith_q <= arith;
            end else if (step) begin
                acc_q <= dir_q ? right_step : sl_out;
                cnt_q <= cnt_q - SHAMT_W'(1);
            end
            if (finish) begin
                data_out_q <= acc_q;
            end
        end
    end

`ifdef SHIFT_SEQ_CARRY_EN
    logic carry_q;
    logic carry_out_q;

    // Carry tracks the bit leaving the accumulator on each step. It is cleared
    // on accept, so a zero-length shift reports 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            if (load) begin
                carry_q <= 1'b0;
            end else if (step) begin
                carry_q <= dir_q ? acc_q[0] : acc_q[WIDTH-1];
            end
            if (finish) begin
                carry_out_q <= carry_q;
            end
        end
    end

    assign carry_out = carry_out_q;
`endif

    assign sl_in    = acc_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule
